// File: rtl/seq_div.sv
// seq_div: unsigned restoring divider, 2*WIDTH-bit dividend / WIDTH-bit divisor; 2*WIDTH clocks load->ready_out.
// load is ignored while busy_out; `SEQ_DIV_DBZ_DET_EN adds dbz_out and a 1-cycle divide-by-zero exit.
module seq_div #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 load,
  output logic [2*WIDTH-1:0]   op_q,
  output logic [WIDTH-1:0]     op_r,
  output logic                 ready_out,
  output logic                 busy_out
`ifdef SEQ_DIV_DBZ_DET_EN
  ,
  output logic                 dbz_out
`endif
);

  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [QW-1:0]    r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_nx;
  logic [QW-1:0]    w_dvd_nx;
  logic             w_ge;
  logic             w_cap;
  logic             w_zero;
  logic             w_last;

  assign w_rem_sh = {r_rem, r_dvd[QW-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  // When w_ge the difference is below the divisor, so WIDTH-bit wraparound is exact.
  assign w_rem_nx = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];
  assign w_dvd_nx = {r_dvd[QW-2:0], w_ge};
  assign w_cap    = load && (r_state != S_BUSY);
  assign w_zero   = (r_dvs == '0);

`ifdef SEQ_DIV_DBZ_DET_EN
  assign w_last = (r_state == S_BUSY) && ((r_cnt == CW'(QW - 1)) || w_zero);
`else
  assign w_last = (r_state == S_BUSY) && (r_cnt == CW'(QW - 1));
`endif

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (load)   w_state_nx = S_BUSY;
      S_BUSY:  if (w_last) w_state_nx = S_DONE;
      S_DONE:  if (load)   w_state_nx = S_BUSY;
      default:             w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      op_q      <= '0;
      op_r      <= '0;
      ready_out <= 1'b0;
      busy_out  <= 1'b0;
`ifdef SEQ_DIV_DBZ_DET_EN
      dbz_out   <= 1'b0;
`endif
    end else if (w_cap) begin
      r_dvd     <= a;
      r_dvs     <= b;
      r_rem     <= '0;
      r_cnt     <= '0;
      ready_out <= 1'b0;
      busy_out  <= 1'b1;
`ifdef SEQ_DIV_DBZ_DET_EN
      dbz_out   <= 1'b0;
`endif
    end else if (r_state == S_BUSY) begin
      r_dvd <= w_dvd_nx;
      r_rem <= w_rem_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        // A zero divisor leaves garbage in the remainder path; publish the fixed result.
        op_q      <= w_zero ? '1 : w_dvd_nx;
        op_r      <= w_zero ? '0 : w_rem_nx;
        ready_out <= 1'b1;
        busy_out  <= 1'b0;
`ifdef SEQ_DIV_DBZ_DET_EN
        dbz_out   <= w_zero;
`endif
      end
    end
  end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Sequential restoring divider; the inverse companion of the team's 4-bit sequential multiplier.
- Accepts a 2*WIDTH-bit dividend (the width of a multiplier product) and a WIDTH-bit divisor.
- Produces a 2*WIDTH-bit quotient and a WIDTH-bit remainder, one quotient bit per clock.
- Sits in the same arithmetic datapath; uses the same load / ready_out handshake style as the multiplier.

Parameters:
- WIDTH, 4, divisor and remainder width; dividend and quotient are 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_a  input  1  asynchronous, active-low reset (asserted when 0).
- a  input  2*WIDTH  dividend, sampled on the load edge.
- b  input  WIDTH  divisor, sampled on the load edge.
- load  input  1  start request, single-cycle or level; sampled only when the divider is not busy.
- op_q  output reg  2*WIDTH  quotient.
- op_r  output reg  WIDTH  remainder.
- ready_out  output reg  1  result valid.
- busy_out  output reg  1  division in progress.

Behaviour:
- Reset (rst_a=0, asynchronous):
  - op_q=0, op_r=0, ready_out=0, busy_out=0.
  - State IDLE; iteration counter 0; internal shift and remainder registers 0.
  - Reset mid-division aborts the operation; no partial result is ever exposed.
- States:
  - IDLE -> BUSY on a clk edge with load=1.
  - BUSY -> DONE when the counter reaches 2*WIDTH.
  - DONE -> BUSY on load=1; otherwise DONE holds.
- Capture edge (load=1 while in IDLE or DONE):
  - Latch a into the dividend shift register and b into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - ready_out<=0, busy_out<=1.
  - op_q and op_r keep their previous values until the new result is written.
- Iterations, on each of the next 2*WIDTH edges:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - If the partial remainder >= divisor: subtract the divisor; quotient bit = 1. Otherwise quotient bit = 0.
  - Quotient bits enter at the LSB of the dividend shift register.
- Completion, on the 2*WIDTH-th iteration edge:
  - op_q and op_r written; ready_out<=1, busy_out<=0; state DONE.
  - Latency: load edge to ready_out = 2*WIDTH clocks (8 for WIDTH=4).
- ready_out stays high and the outputs hold until the next capture edge or reset.
- load while BUSY is ignored entirely; the operation in flight is unaffected.
- load in DONE starts back-to-back: ready_out falls on that edge.
- Arithmetic:
  - Unsigned only; invariant a == op_q*b + op_r with op_r < b whenever b != 0.
  - The quotient always fits in 2*WIDTH bits; no overflow condition exists for b != 0.
- Divide by zero (b=0), without the optional feature:
  - Full 2*WIDTH latency.
  - Result forced to op_q = all ones, op_r = 0.

Optional Feature:
- Macro SEQ_DIV_DBZ_DET_EN.
- When defined:
  - Adds output dbz_out (1 bit), reset value 0.
  - On a capture with b=0, the divider skips iteration: the next edge writes op_q = all ones, op_r=0, ready_out=1, dbz_out=1, busy_out=0 (1-cycle latency).
  - dbz_out clears on the next capture edge or on reset.
  - dbz_out=0 for all nonzero-divisor results.
- When not defined:
  - No dbz_out port.
  - Divide by zero behaves as in Behaviour (full latency, same forced result).

Test Plan:
- Reset, then a=200, b=7, load one cycle -> busy_out=1 for 8 cycles; ready_out=1 on the 8th edge; op_q=28, op_r=4.
- a=255, b=1 -> op_q=255, op_r=0. Then a=9, b=15 -> op_q=0, op_r=9. Then a=225, b=15 -> op_q=15, op_r=0.
- a=100, b=3 started; at cycle 3 drive load with a=50, b=5 -> ignored; result op_q=33, op_r=1.
- a=0, b=0 and a=77, b=0:
  - Without the macro -> after 8 cycles op_q=255, op_r=0.
  - With SEQ_DIV_DBZ_DET_EN -> ready_out=1 and dbz_out=1 one edge after load.
- Mid-division rst_a=0 asynchronously between edges -> all outputs 0 immediately. After release, a=144, b=12 -> op_q=12, op_r=0.
- Back-to-back: load held high in DONE -> ready_out drops for exactly 8 cycles per operation. Exhaustive sweep of all a, b != 0 checks a == op_q*b + op_r.
